// File: rtl/blinker_pkg.sv
// rtl/blinker_pkg.sv - shared types, defaults and width helper for the PWM blinker array
//
// Purpose: common declarations used by pwm_blinker_array and button_debounce.
//   load_mode_t  selects which per-channel register a load writes (period or duty)
//   DEF_*        board defaults: 1 ms tick and 5 ms debounce at 50 MHz
//   width_for()  counter/select width for n states, never less than one bit
package blinker_pkg;

    typedef enum logic {
        MODE_PERIOD = 1'b0,
        MODE_DUTY   = 1'b1
    } load_mode_t;

    localparam int DEF_TICK_DIV = 50000;
    localparam int DEF_DB_LEN   = 250000;

    function automatic int width_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchroniser and debouncer for one active-low push button
//
// Purpose: turns a raw, asynchronous, bouncing active-low button into a single-cycle
//   press pulse. The raw level passes a 2-flop synchroniser and must then differ from
//   the accepted level for DB_LEN consecutive cycles before it is accepted. Accepting
//   a high->low change produces the pulse; accepting a release does not.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   btn_n  in   raw button, low = pressed
//   press  out  one-cycle pulse, 2+DB_LEN cycles after a clean press begins
module button_debounce
    import blinker_pkg::*;
#(
    parameter int DB_LEN = DEF_DB_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press
);

    localparam int CW = width_for(DB_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_LEN - 1);

    logic          sync1;
    logic          sync2;
    logic [1:0]    warm;
    logic          armed;
    logic          level;
    logic [CW-1:0] stable_cnt;

    // The synchroniser resets to "released", so its output is only trusted once
    // warm[1] shows two real samples have passed through. A press is reported only
    // after a genuine release has been seen, so a button held through reset stays
    // silent until it is let go and pressed again.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            warm       <= 2'b00;
            armed      <= 1'b0;
            level      <= 1'b1;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            warm  <= {warm[0], 1'b1};
            press <= 1'b0;
            if (warm[1] && sync2) begin
                armed <= 1'b1;
            end
            if (sync2 != level) begin
                if (stable_cnt == CNT_LAST) begin
                    level      <= sync2;
                    stable_cnt <= '0;
                    press      <= armed & ~sync2;
                end else begin
                    stable_cnt <= stable_cnt + CW'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/pwm_blinker_array.sv
// rtl/pwm_blinker_array.sv - multi-channel programmable PWM LED blinker with blink counters
//
// Purpose: CH independent LED channels, each with a period P and duty D in ticks and a
//   blink counter. A shared prescaler produces one tick every TICK_DIV cycles. Values
//   are loaded from data_wire into the channel picked by ch_sel when the debounced
//   load button is pressed; the debounced mode button toggles whether a load writes
//   the period or the duty.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   but_load     in   raw active-low load button
//   but_mode     in   raw active-low mode-toggle button
//   ch_sel       in   channel select (SEL_W bits)
//   data_wire    in   value to load (W bits)
//   led          out  PWM output per channel
//   mode         out  0 = loads write period, 1 = loads write duty
//   disp_period  out  period of the selected channel, 0 if ch_sel is out of range
//   disp_duty    out  duty of the selected channel, 0 if ch_sel is out of range
//   disp_blinks  out  blink count of the selected channel, 0 if ch_sel is out of range
module pwm_blinker_array
    import blinker_pkg::*;
#(
    parameter  int CH       = 4,
    parameter  int W        = 14,
    parameter  int CNT_W    = 8,
    parameter  int TICK_DIV = DEF_TICK_DIV,
    parameter  int DB_LEN   = DEF_DB_LEN,
    localparam int SEL_W    = width_for(CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             but_load,
    input  logic             but_mode,
    input  logic [SEL_W-1:0] ch_sel,
    input  logic [W-1:0]     data_wire,
    output logic [CH-1:0]    led,
    output logic             mode,
    output logic [W-1:0]     disp_period,
    output logic [W-1:0]     disp_duty,
    output logic [CNT_W-1:0] disp_blinks
);

    localparam int TW = width_for(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic             load_press;
    logic             mode_press;
    logic             tick;
    logic [TW-1:0]    presc;
    load_mode_t       mode_q;
    logic [CH-1:0]    load_hit;

    logic [W-1:0]     period_q [CH];
    logic [W-1:0]     duty_q   [CH];
    logic [W-1:0]     cnt_q    [CH];
    logic [CNT_W-1:0] blk_q    [CH];

    button_debounce #(.DB_LEN(DB_LEN)) u_db_load (
        .clk   (clk),
        .reset (reset),
        .btn_n (but_load),
        .press (load_press)
    );

    button_debounce #(.DB_LEN(DB_LEN)) u_db_mode (
        .clk   (clk),
        .reset (reset),
        .btn_n (but_mode),
        .press (mode_press)
    );

    // Free-running prescaler shared by all channels; loads never disturb it.
    assign tick = (presc == TICK_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + TW'(1);
        end
    end

    // A load applies with the mode in force before any simultaneous toggle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= MODE_PERIOD;
        end else if (mode_press) begin
            mode_q <= (mode_q == MODE_PERIOD) ? MODE_DUTY : MODE_PERIOD;
        end
    end

    assign mode = (mode_q == MODE_DUTY);

    // An out-of-range ch_sel matches no channel, so its load is dropped.
    for (genvar g = 0; g < CH; g++) begin : g_ch
        assign load_hit[g] = load_press && (ch_sel == SEL_W'(g));
        assign led[g]      = (period_q[g] != '0) && (cnt_q[g] < duty_q[g]);
    end

    // A load on a channel takes priority over a coincident tick on that channel; the
    // tick is simply lost there. The blink is counted on the tick that leaves cnt==0,
    // so the first tick after a period load counts blink 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CH; i++) begin
                period_q[i] <= '0;
                duty_q[i]   <= '0;
                cnt_q[i]    <= '0;
                blk_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (load_hit[i]) begin
                    if (mode_q == MODE_PERIOD) begin
                        period_q[i] <= data_wire;
                        cnt_q[i]    <= '0;
                        blk_q[i]    <= '0;
                    end else begin
                        duty_q[i] <= data_wire;
                    end
                end else if (tick && (period_q[i] != '0)) begin
                    if (cnt_q[i] == period_q[i] - W'(1)) begin
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + W'(1);
                    end
                    if (cnt_q[i] == '0) begin
                        blk_q[i] <= blk_q[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        disp_period = '0;
        disp_duty   = '0;
        disp_blinks = '0;
        for (int i = 0; i < CH; i++) begin
            if (ch_sel == SEL_W'(i)) begin
                disp_period = period_q[i];
                disp_duty   = duty_q[i];
                disp_blinks = blk_q[i];
            end
        end
    end

endmodule

// File: tb/tb_pwm_blinker_array.sv
// tb/tb_pwm_blinker_array.sv - self-checking bench for pwm_blinker_array (CH=4 and CH=3)
module tb_pwm_blinker_array;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int W  = 14;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          but_load = 1'b1;
    logic          but_mode = 1'b1;
    logic [1:0]    ch_sel = '0;
    logic [W-1:0]  data_wire = '0;

    logic [3:0]    led_a;
    logic          mode_a;
    logic [W-1:0]  disp_period_a, disp_duty_a;
    logic [CW-1:0] disp_blinks_a;
    logic [2:0]    led_b;
    logic          mode_b;
    logic [W-1:0]  disp_period_b, disp_duty_b;
    logic [CW-1:0] disp_blinks_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pwm_blinker_array #(.CH(4), .W(W), .CNT_W(CW), .TICK_DIV(TD), .DB_LEN(DB)) dut_a (
        .clk(clk), .reset(reset), .but_load(but_load), .but_mode(but_mode),
        .ch_sel(ch_sel), .data_wire(data_wire), .led(led_a), .mode(mode_a),
        .disp_period(disp_period_a), .disp_duty(disp_duty_a), .disp_blinks(disp_blinks_a)
    );

    pwm_blinker_array #(.CH(3), .W(W), .CNT_W(CW), .TICK_DIV(TD), .DB_LEN(DB)) dut_b (
        .clk(clk), .reset(reset), .but_load(but_load), .but_mode(but_mode),
        .ch_sel(ch_sel), .data_wire(data_wire), .led(led_b), .mode(mode_b),
        .disp_period(disp_period_b), .disp_duty(disp_duty_b), .disp_blinks(disp_blinks_b)
    );

    // Reference model: per channel the period, duty and the number of ticks counted
    // since the last period load; cnt and blink count follow arithmetically from that.
    int nch [2] = '{4, 3};
    int m_p   [2][4];
    int m_d   [2][4];
    int m_ph  [2][4];
    bit m_mode;
    bit m_load_p, m_mode_p;
    int m_hist [2][8];
    int m_level [2];
    bit m_armed [2];
    int m_edges;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                m_p[d][i] = 0; m_d[d][i] = 0; m_ph[d][i] = 0;
            end
            for (int k = 0; k < 8; k++) m_hist[d][k] = -1;
            m_level[d] = 1;
            m_armed[d] = 0;
        end
        m_mode = 0; m_load_p = 0; m_mode_p = 0; m_edges = 0;
    endtask

    // A button level is accepted once the synchronised samples (raw delayed two
    // edges) have differed from the accepted level for DB edges in a row; samples
    // from before reset release read as released. A press only counts once a real
    // release has been observed.
    task automatic db_model(input int b, input bit raw, output bit pulse);
        bit all_diff;
        int v;
        for (int k = 7; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
        m_hist[b][0] = raw;
        all_diff = 1;
        for (int k = 2; k <= DB + 1; k++) begin
            v = (m_hist[b][k] < 0) ? 1 : m_hist[b][k];
            if (v == m_level[b]) all_diff = 0;
        end
        pulse = 0;
        if (all_diff) begin
            m_level[b] = 1 - m_level[b];
            pulse = (m_level[b] == 0) && m_armed[b];
        end
        if (m_hist[b][2] == 1) m_armed[b] = 1;
    endtask

    task automatic model_edge();
        bit tick, lp, mp;
        tick = (m_edges % TD) == TD - 1;
        m_edges++;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < nch[d]; i++) begin
                if (m_load_p && int'(ch_sel) == i) begin
                    if (!m_mode) begin
                        m_p[d][i] = int'(data_wire);
                        m_ph[d][i] = 0;
                    end else begin
                        m_d[d][i] = int'(data_wire);
                    end
                end else if (tick && m_p[d][i] != 0) begin
                    m_ph[d][i]++;
                end
            end
        end
        if (m_mode_p) m_mode = !m_mode;
        db_model(0, but_load, lp);
        db_model(1, but_mode, mp);
        m_load_p = lp;
        m_mode_p = mp;
    endtask

    function automatic int exp_led(input int d, input int i);
        if (m_p[d][i] == 0) return 0;
        return ((m_ph[d][i] % m_p[d][i]) < m_d[d][i]) ? 1 : 0;
    endfunction

    function automatic int exp_blk(input int d, input int i);
        if (m_p[d][i] == 0) return 0;
        return ((m_ph[d][i] + m_p[d][i] - 1) / m_p[d][i]) % 256;
    endfunction

    task automatic compare_all();
        int s;
        s = int'(ch_sel);
        for (int i = 0; i < 4; i++) check($sformatf("led_a[%0d]", i), led_a[i], exp_led(0, i));
        for (int i = 0; i < 3; i++) check($sformatf("led_b[%0d]", i), led_b[i], exp_led(1, i));
        check("mode_a", mode_a, m_mode);
        check("mode_b", mode_b, m_mode);
        check("period_a", disp_period_a, m_p[0][s]);
        check("duty_a", disp_duty_a, m_d[0][s]);
        check("blinks_a", disp_blinks_a, exp_blk(0, s));
        check("period_b", disp_period_b, (s < 3) ? m_p[1][s] : 0);
        check("duty_b", disp_duty_b, (s < 3) ? m_d[1][s] : 0);
        check("blinks_b", disp_blinks_b, (s < 3) ? exp_blk(1, s) : 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic press(input bit ld, input bit md, input int hold);
        if (ld) but_load = 1'b0;
        if (md) but_mode = 1'b0;
        run(hold);
        but_load = 1'b1;
        but_mode = 1'b1;
        run(DB + 4);
    endtask

    task automatic load(input int sel, input int val);
        ch_sel = 2'(sel);
        data_wire = W'(val);
        press(1, 0, 6);
    endtask

    task automatic set_mode(input bit want);
        if (m_mode != want) press(0, 1, 6);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_led_a"}, led_a, 0);
        check({tag, "_led_b"}, led_b, 0);
        check({tag, "_mode_a"}, mode_a, 0);
        check({tag, "_period_a"}, disp_period_a, 0);
        check({tag, "_duty_a"}, disp_duty_a, 0);
        check({tag, "_blinks_a"}, disp_blinks_a, 0);
        check({tag, "_period_b"}, disp_period_b, 0);
    endtask

    int cnt_hi, b0, om, r, guard;

    initial begin
        model_reset();
        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        reset = 1'b1;
        run(4);

        // Channel 0: P=4, D=2 -> 8 cycles high, 8 low, one blink per 16 cycles
        load(0, 4);
        press(0, 1, 6);
        load(0, 2);
        run(5);
        cnt_hi = 0;
        b0 = int'(disp_blinks_a);
        for (int k = 0; k < 32; k++) begin
            step();
            cnt_hi += int'(led_a[0]);
        end
        check("pwm_high_cycles", cnt_hi, 16);
        check("blinks_per_32", (int'(disp_blinks_a) - b0 + 256) % 256, 2);

        // Channel 1: P=0 keeps it dark and frozen; D>P gives constant on
        set_mode(0);
        load(1, 0);
        set_mode(1);
        load(1, 3);
        run(30);
        check("p0_led", led_a[1], 0);
        check("p0_blinks", disp_blinks_a, 0);
        load(1, 5);
        set_mode(0);
        load(1, 4);
        cnt_hi = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            cnt_hi += int'(led_a[1]);
        end
        check("dgep_on_cycles", cnt_hi, 20);

        // Bounce shorter than DB is ignored, a long press loads once
        ch_sel = 2'd3;
        data_wire = W'(7);
        press(1, 0, 2);
        run(5);
        check("bounce_no_load", disp_period_a, 0);
        press(1, 0, 6);
        check("long_press_load", disp_period_a, 7);

        // Reset mid-run with the load button held through release
        ch_sel = 2'd0;
        data_wire = W'(9);
        but_load = 1'b0;
        reset = 1'b0;
        #2;
        check_zero_outputs("midrst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        run(15);
        check("held_no_load", disp_period_a, 0);
        but_load = 1'b1;
        run(DB + 4);
        press(1, 0, 6);
        check("load_after_release", disp_period_a, 9);

        // Channel 2: blink counter reaches 255, reload clears it, then full wrap
        load(2, 3);
        guard = 0;
        while (exp_blk(0, 2) != 255 && guard < 4000) begin
            step();
            guard++;
        end
        check("blk255_reached", disp_blinks_a, 255);
        press(1, 0, 6);
        check("blk_cleared", disp_blinks_a <= 2, 1);
        run(256 * 3 * TD);
        check("blk_wrapped", disp_blinks_a <= 3, 1);

        // Simultaneous load and mode press: old mode picks the target, mode flips
        ch_sel = 2'd1;
        data_wire = W'(11);
        om = m_mode;
        press(1, 1, 6);
        if (om == 0) check("sim_period", disp_period_a, 11);
        else         check("sim_duty", disp_duty_a, 11);
        check("sim_mode_flip", mode_a, !om);

        // Out-of-range select on the 3-channel instance
        ch_sel = 2'd3;
        data_wire = W'(13);
        press(1, 0, 6);
        check("sel3_b_period", disp_period_b, 0);
        check("sel3_b_duty", disp_duty_b, 0);

        // Randomised operation against the model
        for (int it = 0; it < 250; it++) begin
            ch_sel = 2'($urandom_range(0, 3));
            data_wire = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40))
                                                    : W'($urandom_range(0, 8));
            r = $urandom_range(0, 9);
            if (r < 5)      press(1, 0, $urandom_range(1, 6));
            else if (r < 7) press(0, 1, $urandom_range(1, 6));
            else if (r < 8) press(1, 1, $urandom_range(2, 6));
            else            run($urandom_range(1, 20));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
